// File: rtl/stream_mem_loader.sv
// UART byte-stream loader: WRITE/READ commands move 32-bit words to/from a synchronous memory.
// Define STREAM_LOADER_DONE_ACK_EN to send a 0xAA acknowledge byte after every WRITE.
module stream_mem_loader #(
    parameter int ADDR_WIDTH    = 16,
    parameter int BYTE_ORDER_LE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_stb,
    output logic [7:0]            tx_data,
    output logic                  tx_stb,
    input  logic                  tx_ack,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_dw,
    input  logic [31:0]           mem_dr,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE, HDR, WR_COLLECT, WR_MEM, RD_MEM, RD_WAIT, TX_BYTE
`ifdef STREAM_LOADER_DONE_ACK_EN
        , DONE_ACK
`endif
    } state_t;

`ifdef STREAM_LOADER_DONE_ACK_EN
    localparam state_t WR_END = DONE_ACK;
`else
    localparam state_t WR_END = IDLE;
`endif

    state_t                  state_q, state_d;
    logic                    is_read_q, is_read_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [15:0]             n_q, n_d;
    logic [31:0]             buf_q, buf_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    tx_stb_q, tx_stb_d;
    logic [1:0]              lane;
    logic [15:0]             hdr_n;

    // Byte lane inside the word for the current byte index.
    assign lane  = (BYTE_ORDER_LE != 0) ? cnt_q : (2'd3 - cnt_q);
    assign hdr_n = {buf_q[7:0], rx_data};

    always_comb begin
        state_d   = state_q;
        is_read_d = is_read_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        n_d       = n_q;
        buf_d     = buf_q;
        tx_data_d = tx_data_q;
        tx_stb_d  = tx_stb_q;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_stb && (rx_data == 8'h01 || rx_data == 8'h02)) begin
                    is_read_d = rx_data[1];
                    cnt_d     = 2'd0;
                    state_d   = HDR;
                end
            end
            HDR: begin
                if (rx_stb) begin
                    buf_d = {buf_q[23:0], rx_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        addr_d = ADDR_WIDTH'(buf_q[23:8]);
                        n_d    = hdr_n;
                        buf_d  = '0;
                        if (hdr_n == 16'd0)
                            state_d = IDLE;
                        else if (is_read_q)
                            state_d = RD_MEM;
                        else
                            state_d = WR_COLLECT;
                    end
                end
            end
            WR_COLLECT: begin
                if (rx_stb) begin
                    buf_d[{lane, 3'b000} +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3)
                        state_d = WR_MEM;
                end
            end
            WR_MEM: begin
                mem_en  = 1'b1;
                mem_we  = 1'b1;
                addr_d  = addr_q + ADDR_WIDTH'(1);
                n_d     = n_q - 16'd1;
                state_d = (n_q == 16'd1) ? WR_END : WR_COLLECT;
            end
            RD_MEM: begin
                mem_en  = 1'b1;
                addr_d  = addr_q + ADDR_WIDTH'(1);
                n_d     = n_q - 16'd1;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                buf_d   = mem_dr;
                cnt_d   = 2'd0;
                state_d = TX_BYTE;
            end
            TX_BYTE: begin
                // Strobe drops for the cycle after each ack, giving the mandatory gap.
                if (tx_stb_q) begin
                    if (tx_ack) begin
                        tx_stb_d = 1'b0;
                        cnt_d    = cnt_q + 2'd1;
                        if (cnt_q == 2'd3)
                            state_d = (n_q == 16'd0) ? IDLE : RD_MEM;
                    end
                end else begin
                    tx_stb_d  = 1'b1;
                    tx_data_d = buf_q[{lane, 3'b000} +: 8];
                end
            end
`ifdef STREAM_LOADER_DONE_ACK_EN
            DONE_ACK: begin
                if (tx_stb_q) begin
                    if (tx_ack) begin
                        tx_stb_d = 1'b0;
                        state_d  = IDLE;
                    end
                end else begin
                    tx_stb_d  = 1'b1;
                    tx_data_d = 8'hAA;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            is_read_q <= 1'b0;
            cnt_q     <= 2'd0;
            addr_q    <= '0;
            n_q       <= 16'd0;
            buf_q     <= 32'd0;
            tx_data_q <= 8'd0;
            tx_stb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_read_q <= is_read_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            n_q       <= n_d;
            buf_q     <= buf_d;
            tx_data_q <= tx_data_d;
            tx_stb_q  <= tx_stb_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_stb   = tx_stb_q;
    assign mem_addr = addr_q;
    assign mem_dw   = buf_q;
    assign busy     = (state_q != IDLE);

endmodule
